// File: rtl/fix22_to_fp32_pipe.sv
// fix22_to_fp32_pipe
//   Three-stage pipelined converter from Q2.19 two's-complement fixed point
//   (CORDIC cos_out) to IEEE-754 single precision. The conversion is always
//   exact because the input never carries more than 22 significant bits.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   enable     pipeline advance; when low, every stage holds data and valid
//   in_valid   fixed_in is meaningful this cycle
//   fixed_in   Q2.19 two's-complement input
//   out_valid  float_out is meaningful
//   float_out  FP32 result {sign, exp[7:0], mant[22:0]}
//   busy       OR of all stage valid bits
module fix22_to_fp32_pipe #(
  parameter int unsigned IN_W   = 22,
  parameter int unsigned FRAC_W = 19,
  parameter int unsigned BIAS   = 127
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            in_valid,
  input  logic [IN_W-1:0] fixed_in,
  output logic            out_valid,
  output logic [31:0]     float_out,
  output logic            busy
);

  localparam int unsigned P_W = $clog2(IN_W);

  // Stage 1: sign / magnitude
  logic            s1_valid_q, s1_valid_d;
  logic            s1_sign_q,  s1_sign_d;
  logic [IN_W-1:0] s1_mag_q,   s1_mag_d;

  // Stage 2: normalised fraction (implied leading 1 dropped), leading-one index
  logic            s2_valid_q, s2_valid_d;
  logic            s2_sign_q,  s2_sign_d;
  logic            s2_zero_q,  s2_zero_d;
  logic [P_W-1:0]  s2_pos_q,   s2_pos_d;
  logic [IN_W-2:0] s2_norm_q,  s2_norm_d;

  // Stage 3: packed result
  logic            s3_valid_q, s3_valid_d;
  logic [31:0]     s3_float_q, s3_float_d;

  logic [P_W-1:0]  lead_pos;
  logic [IN_W-1:0] norm_full;
  logic [7:0]      exp_val;
  logic [22:0]     mant_val;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_mag_d   = s1_mag_q;
    if (enable) begin
      s1_valid_d = in_valid;
      s1_sign_d  = fixed_in[IN_W-1];
      // The most negative input negates to itself, which read as unsigned is
      // exactly its magnitude.
      s1_mag_d   = fixed_in[IN_W-1] ? -fixed_in : fixed_in;
    end
  end

  always_comb begin
    lead_pos = '0;
    for (int unsigned i = 0; i < IN_W; i++) begin
      if (s1_mag_q[i]) lead_pos = P_W'(i);
    end
    norm_full = s1_mag_q << (P_W'(IN_W - 1) - lead_pos);
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_zero_d  = s2_zero_q;
    s2_pos_d   = s2_pos_q;
    s2_norm_d  = s2_norm_q;
    if (enable) begin
      s2_valid_d = s1_valid_q;
      s2_sign_d  = s1_sign_q;
      // After normalisation the top bit is set for every non-zero magnitude.
      s2_zero_d  = ~norm_full[IN_W-1];
      s2_pos_d   = lead_pos;
      s2_norm_d  = norm_full[IN_W-2:0];
    end
  end

  always_comb begin
    exp_val  = 8'(BIAS - FRAC_W) + 8'(s2_pos_q);
    mant_val = {s2_norm_q, {(24 - IN_W){1'b0}}};
  end

  always_comb begin
    s3_valid_d = s3_valid_q;
    s3_float_d = s3_float_q;
    if (enable) begin
      s3_valid_d = s2_valid_q;
      s3_float_d = s2_zero_q ? '0 : {s2_sign_q, exp_val, mant_val};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_mag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_pos_q   <= '0;
      s2_norm_q  <= '0;
      s3_valid_q <= 1'b0;
      s3_float_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_mag_q   <= s1_mag_d;
      s2_valid_q <= s2_valid_d;
      s2_sign_q  <= s2_sign_d;
      s2_zero_q  <= s2_zero_d;
      s2_pos_q   <= s2_pos_d;
      s2_norm_q  <= s2_norm_d;
      s3_valid_q <= s3_valid_d;
      s3_float_q <= s3_float_d;
    end
  end

  assign out_valid = s3_valid_q;
  assign float_out = s3_float_q;
  assign busy      = s1_valid_q | s2_valid_q | s3_valid_q;

endmodule

// File: tb/tb_fix22_to_fp32_pipe.sv
module tb_fix22_to_fp32_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        in_valid;
  logic [21:0] fixed_in;
  logic        out_valid;
  logic [31:0] float_out;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  // Expected-occupancy model: three slots of {valid, expected result}.
  logic        mv [3];
  logic [31:0] me [3];

  fix22_to_fp32_pipe #(.IN_W(22), .FRAC_W(19), .BIAS(127)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .in_valid  (in_valid),
    .fixed_in  (fixed_in),
    .out_valid (out_valid),
    .float_out (float_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Reference: value as a real, converted via the double-precision encoding.
  function automatic logic [31:0] ref_fp(input logic [21:0] x);
    real         r;
    logic [63:0] b;
    logic [10:0] e;
    if (x == 22'h0) return 32'h0;
    r = real'($signed(x)) / 524288.0;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      mv[i] = 1'b0;
      me[i] = 32'h0;
    end
  endtask

  task automatic cycle(input logic en, input logic vld, input logic [21:0] din,
                       input logic [31:0] exp_v);
    enable   = en;
    in_valid = vld;
    fixed_in = din;
    @(posedge clk);
    #1;
    if (!reset) begin
      model_clear();
    end else if (en) begin
      mv[2] = mv[1]; me[2] = me[1];
      mv[1] = mv[0]; me[1] = me[0];
      mv[0] = vld;   me[0] = exp_v;
    end
    chk("out_valid", {31'b0, out_valid}, {31'b0, mv[2]});
    chk("busy", {31'b0, busy}, {31'b0, mv[0] | mv[1] | mv[2]});
    if (mv[2] || !reset) chk("float_out", float_out, me[2]);
  endtask

  initial begin
    logic [21:0] d;
    logic        en, vld;
    model_clear();
    reset    = 1'b0;
    enable   = 1'b0;
    in_valid = 1'b0;
    fixed_in = 22'h0;

    // Reset held for two cycles
    cycle(1'b1, 1'b1, 22'h080000, 32'h0);
    cycle(1'b1, 1'b1, 22'h080000, 32'h0);
    reset = 1'b1;

    // Warm-up: 1.0 appears on the third enabled edge
    cycle(1'b1, 1'b1, 22'h080000, 32'h3F800000);
    cycle(1'b1, 1'b0, 22'h0, 32'h0);
    cycle(1'b1, 1'b0, 22'h0, 32'h0);
    chk("warmup_valid", {31'b0, out_valid}, 32'h1);
    chk("warmup_value", float_out, 32'h3F800000);

    // Back-to-back value sweep
    cycle(1'b1, 1'b1, 22'h0F0000, 32'h3FF00000);
    cycle(1'b1, 1'b1, 22'h380000, 32'hBF800000);
    cycle(1'b1, 1'b1, 22'h200000, 32'hC0800000);
    cycle(1'b1, 1'b1, 22'h1FFFFF, 32'h407FFFF8);
    cycle(1'b1, 1'b1, 22'h000001, 32'h36000000);
    cycle(1'b1, 1'b1, 22'h000000, 32'h00000000);
    cycle(1'b1, 1'b1, 22'h3FFFFF, 32'hB6000000);
    cycle(1'b1, 1'b1, 22'h100000, 32'h40000000);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 22'h0, 32'h0);

    // Enable stall with three samples issued; inputs offered during the stall are ignored
    cycle(1'b1, 1'b1, 22'h040000, 32'h3F000000);
    cycle(1'b1, 1'b1, 22'h0C0000, 32'h3FC00000);
    cycle(1'b1, 1'b1, 22'h3C0000, 32'hBF000000);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 22'h155555, 32'hDEADBEEF);
    cycle(1'b1, 1'b1, 22'h020000, 32'h3E800000);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 22'h0, 32'h0);

    // Bubble pattern 1,0,1,1,0 then drain
    cycle(1'b1, 1'b1, 22'h080000, 32'h3F800000);
    cycle(1'b1, 1'b0, 22'h0AAAAA, 32'h0);
    cycle(1'b1, 1'b1, 22'h280000, 32'hC0400000);
    cycle(1'b1, 1'b1, 22'h000010, 32'h38000000);
    cycle(1'b1, 1'b0, 22'h155555, 32'h0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 22'h0, 32'h0);
    chk("drained_busy", {31'b0, busy}, 32'h0);

    // Mid-stream asynchronous reset pulse between edges
    cycle(1'b1, 1'b1, 22'h080000, 32'h3F800000);
    cycle(1'b1, 1'b1, 22'h0F0000, 32'h3FF00000);
    cycle(1'b1, 1'b1, 22'h380000, 32'hBF800000);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("async_rst_busy", {31'b0, busy}, 32'h0);
    chk("async_rst_float", float_out, 32'h0);
    reset = 1'b1;
    model_clear();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 22'h0, 32'h0);

    // Random traffic against the real-valued reference
    for (int i = 0; i < 3000; i++) begin
      d   = 22'($urandom);
      if (i % 7 == 0) d = 22'h200000;
      if (i % 11 == 0) d = 22'h0;
      en  = ($urandom_range(3) != 0);
      vld = 1'($urandom_range(1));
      cycle(en, vld, d, ref_fp(d));
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 22'h0, 32'h0);
    chk("final_busy", {31'b0, busy}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
